td4_run_ctrl: RTL and testbench
===============================

// Module: td4_run_ctrl
// PURPOSE
//  Run controller and program-memory arbiter for the TD4 4-bit CPU core.
//  Owns the 16x8 program memory. Lets a host loader write it while the CPU is stopped.
//  Serves combinational instruction fetch to the core and sequences execution (reset/run/step/halt).
//  Advances the core only through a one-cycle instruction tick (cpu_tick), issued at a programmable rate.
// PARAMETERS
//  DIV     4   clk cycles per cpu_tick in RUN (>=1; 1 = tick every cycle)
//  ADDR_W  4   program address width (memory depth 2**ADDR_W)
//  DATA_W  8   instruction width
//  CNT_W   16  executed-instruction counter width
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  cmd_run       in   1       level/pulse: start or resume continuous execution
//  cmd_step      in   1       pulse: execute exactly one instruction
//  cmd_halt      in   1       pulse: stop after current cycle
//  cmd_reset     in   1       pulse: return to IDLE, hold core in reset
//  host_wr_valid in   1       host write request
//  host_wr_ready out  1       memory writable (IDLE or HALT)
//  host_wr_addr  in   ADDR_W  write address
//  host_wr_data  in   DATA_W  write data
//  cpu_adr       in   ADDR_W  core PC (fetch address)
//  cpu_dat       out  DATA_W  instruction at cpu_adr (combinational read)
//  cpu_tick      out  1       one-cycle instruction enable to core
//  cpu_rst_n     out  1       core clear, active-low (drives core Clear_bar inputs)
//  state         out  2       current state encoding
//  instr_cnt     out  CNT_W   ticks issued since leaving IDLE, saturating
//  bp_en         in   1       breakpoint enable (see CONFIGURATION)
//  bp_addr       in   ADDR_W  breakpoint PC
//  bp_hit        out  1       one-cycle pulse on breakpoint stop
// BEHAVIOUR
//  Reset values: state=IDLE, cpu_rst_n=0, cpu_tick=0, instr_cnt=0, bp_hit=0, div_cnt=0, host_wr_ready=1.
//  rst does not clear the memory array; contents are undefined until loaded.
//  States: IDLE=0, RUN=1, HALT=2, STEP=3. Command priority when simultaneous: reset > halt > step > run.
//   IDLE: cpu_rst_n=0.
//     cmd_run  -> RUN;  cmd_step -> STEP.
//     cpu_rst_n goes 1 in the cycle after the transition edge.
//   RUN: div_cnt counts 0..DIV-1 and is cleared on RUN entry.
//     cpu_tick=1 in the cycle where div_cnt==DIV-1, so the first tick comes DIV cycles after entry.
//     cmd_halt -> HALT, and no tick is issued in that cycle.
//   STEP: lasts exactly one cycle, cpu_tick=1, then -> HALT.
//   HALT: no ticks; core state is held (cpu_rst_n=1).
//     cmd_run -> RUN (resume, no core reset); cmd_step -> STEP.
//   Any state: cmd_reset -> IDLE; instr_cnt cleared on IDLE entry.
//  Host writes:
//   - host_wr_ready=1 only in IDLE or HALT.
//   - A write commits at the edge where valid&ready.
//   - Writes with valid while not ready are dropped, not queued; the host must retry.
//  Same-address write/fetch: cpu_dat shows old data until the write edge, new data after it.
//  instr_cnt += 1 per cpu_tick; it saturates at 2**CNT_W-1 (no wrap).
//  cpu_dat is a pure function of cpu_adr and memory; no added latency.
//  PC wrap 15->0 is the core's concern; this controller places no restriction on it.
// CONFIGURATION
//  Macro TD4_BREAKPOINT_EN.
//  Defined:
//   - In RUN, when a tick is due and bp_en && cpu_adr==bp_addr, the tick is suppressed.
//   - State -> HALT and bp_hit pulses for 1 cycle.
//   - The first tick after resuming from HALT ignores the breakpoint, so execution can continue past it.
//   - STEP never breaks.
//  Undefined: bp_en and bp_addr are ignored; bp_hit is tied 0; port list is unchanged.
// STRUCTURE
//  Package td4_pkg:
//   - state encoding constants (ST_IDLE, ST_RUN, ST_HALT, ST_STEP)
//   - TD4_ADDR_W=4, TD4_DATA_W=8
//  Sub-module td4_prog_mem: 2**ADDR_W x DATA_W array, one synchronous write port, one async read port.
//  The controller FSM, divider and counter stay in td4_run_ctrl.
// TESTING
//  1 Reset, then write 0xB3@0, 0xB5@1, 0xF0@2 in IDLE.
//    -> ready=1, cpu_dat follows cpu_adr, cpu_rst_n=0, no ticks.
//  2 DIV=4, cmd_run from IDLE.
//    -> cpu_rst_n=1 next cycle; ticks at entry+4, +8, +12...
//    -> instr_cnt=3 after the third tick.
//  3 HALT, then cmd_step x2.
//    -> exactly two single-cycle ticks, one cycle after each command; state returns to HALT.
//  4 Host write during RUN.
//    -> ready=0, memory unchanged. Then halt, write 0x00@1 -> cpu_dat=0x00 when cpu_adr=1.
//  5 cmd_halt and cmd_run in the same cycle in RUN -> HALT.
//    cmd_reset mid-RUN -> IDLE, cpu_rst_n=0, instr_cnt=0.
//  6 TD4_BREAKPOINT_EN defined, bp_addr=2, run.
//    -> tick withheld at PC=2, bp_hit pulse, HALT.
//    -> cmd_run resumes past PC 2. Macro undefined: no stop.

Source files
------------

// File: rtl/td4_pkg.sv
// td4_pkg: shared definitions for the TD4 run controller slice.
//   TD4_ADDR_W / TD4_DATA_W : default program address and instruction widths
//   td4_state_e             : controller state encoding (ST_IDLE/ST_RUN/ST_HALT/ST_STEP)
//   mem_writable()          : states in which the host may write program memory
package td4_pkg;

   localparam int unsigned TD4_ADDR_W = 4;
   localparam int unsigned TD4_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2,
      ST_STEP = 2'd3
   } td4_state_e;

   function automatic logic mem_writable(input td4_state_e s);
      return (s == ST_IDLE) || (s == ST_HALT);
   endfunction

endpackage

// File: rtl/td4_run_ctrl_if.sv
// td4_run_ctrl_if: host loader write channel into the TD4 program memory.
//   host_wr_valid : write request            (master -> slave)
//   host_wr_ready : memory currently writable (slave -> master)
//   host_wr_addr  : write address            (master -> slave)
//   host_wr_data  : write data               (master -> slave)
// A write commits on the clock edge where valid and ready are both high.
interface td4_run_ctrl_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
);

   logic              host_wr_valid;
   logic              host_wr_ready;
   logic [ADDR_W-1:0] host_wr_addr;
   logic [DATA_W-1:0] host_wr_data;

   modport master (
      output host_wr_valid,
      output host_wr_addr,
      output host_wr_data,
      input  host_wr_ready
   );

   modport slave (
      input  host_wr_valid,
      input  host_wr_addr,
      input  host_wr_data,
      output host_wr_ready
   );

endinterface

// File: rtl/td4_prog_mem.sv
// td4_prog_mem: 2**ADDR_W x DATA_W program store.
//   clk     : write clock
//   wr_en   : commit wr_data at wr_addr on the rising edge
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : fetch address (asynchronous read)
//   rd_data : word at rd_addr; shows the old word until a same-address write edge
// The array has no reset; contents are undefined until loaded.
module td4_prog_mem #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/td4_run_ctrl.sv
// td4_run_ctrl: run controller and program-memory arbiter for the TD4 4-bit core.
//   clk, rst          : clock, asynchronous active-high reset
//   cmd_run/step/halt/reset : execution commands (priority reset > halt > step > run)
//   host              : host write channel (td4_run_ctrl_if.slave), writable in IDLE/HALT
//   cpu_adr / cpu_dat : core fetch address / combinational instruction read
//   cpu_tick          : one-cycle instruction enable to the core
//   cpu_rst_n         : core clear, active-low, low only in IDLE
//   state             : current state encoding (IDLE=0 RUN=1 HALT=2 STEP=3)
//   instr_cnt         : ticks issued since leaving IDLE, saturating
//   bp_en, bp_addr, bp_hit : PC breakpoint, active only when TD4_BREAKPOINT_EN is defined;
//                      otherwise bp_en/bp_addr are ignored and bp_hit is 0.
module td4_run_ctrl
   import td4_pkg::*;
#(
   parameter int unsigned DIV    = 4,
   parameter int unsigned ADDR_W = TD4_ADDR_W,
   parameter int unsigned DATA_W = TD4_DATA_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_run,
   input  logic              cmd_step,
   input  logic              cmd_halt,
   input  logic              cmd_reset,
   td4_run_ctrl_if.slave     host,
   input  logic [ADDR_W-1:0] cpu_adr,
   output logic [DATA_W-1:0] cpu_dat,
   output logic              cpu_tick,
   output logic              cpu_rst_n,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  instr_cnt,
   input  logic              bp_en,
   input  logic [ADDR_W-1:0] bp_addr,
   output logic              bp_hit
);

   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   td4_state_e       state_q, state_d;
   logic [DIV_W-1:0] div_cnt;
   logic             tick_due;
   logic             bp_stop;
   logic             mem_wr_en;

   // ---------------------------------------------------------------- memory
   assign host.host_wr_ready = mem_writable(state_q);
   assign mem_wr_en          = host.host_wr_valid && host.host_wr_ready;

   td4_prog_mem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (mem_wr_en),
      .wr_addr (host.host_wr_addr),
      .wr_data (host.host_wr_data),
      .rd_addr (cpu_adr),
      .rd_data (cpu_dat)
   );

   // ---------------------------------------------------------------- divider
   // Held at zero outside RUN, so every entry into RUN starts a fresh period
   // and the first tick lands DIV cycles after entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (state_q != ST_RUN) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tick_due = (state_q == ST_RUN) && (div_cnt == DIV_LAST);

   // ---------------------------------------------------------------- breakpoint
`ifdef TD4_BREAKPOINT_EN
   logic bp_skip;

   // Armed on HALT->RUN resume so the first tick may execute the instruction
   // sitting at the breakpoint; disarmed by that tick or by leaving RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bp_skip <= 1'b0;
      end else if (state_q == ST_HALT && state_d == ST_RUN) begin
         bp_skip <= 1'b1;
      end else if (cpu_tick || state_q != ST_RUN) begin
         bp_skip <= 1'b0;
      end
   end

   assign bp_stop = tick_due && bp_en && (cpu_adr == bp_addr) && !bp_skip;
`else
   logic unused_bp;
   assign unused_bp = ^{bp_en, bp_addr};
   assign bp_stop   = 1'b0;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cpu_tick = 1'b0;
      bp_hit   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_step) begin
               state_d = ST_STEP;
            end else if (cmd_run) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cmd_halt) begin
               state_d = ST_HALT;
            end else if (bp_stop) begin
               state_d = ST_HALT;
               bp_hit  = !cmd_reset;
            end
            // A tick is withheld whenever the run is being stopped this cycle.
            cpu_tick = tick_due && !cmd_halt && !cmd_reset && !bp_stop;
         end
         ST_HALT: begin
            if (cmd_step) begin
               state_d = ST_STEP;
            end else if (cmd_run) begin
               state_d = ST_RUN;
            end
         end
         ST_STEP: begin
            state_d  = ST_HALT;
            cpu_tick = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      if (cmd_reset) begin
         state_d = ST_IDLE;
      end
   end

   assign state     = state_q;
   assign cpu_rst_n = (state_q != ST_IDLE);

   // ---------------------------------------------------------------- counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_cnt <= '0;
      end else if (state_d == ST_IDLE) begin
         instr_cnt <= '0;
      end else if (cpu_tick && (instr_cnt != '1)) begin
         instr_cnt <= instr_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_td4_run_ctrl.sv
module tb_td4_run_ctrl;
   import td4_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_run, cmd_step, cmd_halt, cmd_reset;
   logic [3:0] cpu_adr;
   logic [7:0] cpu_dat;
   logic       cpu_tick, cpu_rst_n, bp_en, bp_hit;
   logic [1:0] state;
   logic [15:0] instr_cnt;
   logic [3:0] bp_addr;

   // second instance: DIV=1 and a 3-bit counter for the saturation boundary
   logic       s_run;
   logic [3:0] s_adr;
   logic [7:0] s_dat;
   logic       s_tick, s_rst_n, s_bp_hit;
   logic [1:0] s_state;
   logic [2:0] s_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   td4_run_ctrl_if #(.ADDR_W(4), .DATA_W(8)) hif ();
   td4_run_ctrl_if #(.ADDR_W(4), .DATA_W(8)) sif ();

   td4_run_ctrl #(.DIV(4), .ADDR_W(4), .DATA_W(8), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_run   (cmd_run),
      .cmd_step  (cmd_step),
      .cmd_halt  (cmd_halt),
      .cmd_reset (cmd_reset),
      .host      (hif.slave),
      .cpu_adr   (cpu_adr),
      .cpu_dat   (cpu_dat),
      .cpu_tick  (cpu_tick),
      .cpu_rst_n (cpu_rst_n),
      .state     (state),
      .instr_cnt (instr_cnt),
      .bp_en     (bp_en),
      .bp_addr   (bp_addr),
      .bp_hit    (bp_hit)
   );

   td4_run_ctrl #(.DIV(1), .ADDR_W(4), .DATA_W(8), .CNT_W(3)) dut_sat (
      .clk       (clk),
      .rst       (rst),
      .cmd_run   (s_run),
      .cmd_step  (1'b0),
      .cmd_halt  (1'b0),
      .cmd_reset (1'b0),
      .host      (sif.slave),
      .cpu_adr   (s_adr),
      .cpu_dat   (s_dat),
      .cpu_tick  (s_tick),
      .cpu_rst_n (s_rst_n),
      .state     (s_state),
      .instr_cnt (s_cnt),
      .bp_en     (1'b0),
      .bp_addr   (4'd0),
      .bp_hit    (s_bp_hit)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [3:0] a, input logic [7:0] d);
      hif.host_wr_valid = 1'b1;
      hif.host_wr_addr  = a;
      hif.host_wr_data  = d;
      step_clk();
      hif.host_wr_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      cmd_run = 0; cmd_step = 0; cmd_halt = 0; cmd_reset = 0;
      cpu_adr = 4'd0; bp_en = 1'b0; bp_addr = 4'd0;
      hif.host_wr_valid = 0; hif.host_wr_addr = '0; hif.host_wr_data = '0;
      sif.host_wr_valid = 0; sif.host_wr_addr = '0; sif.host_wr_data = '0;
      s_run = 0; s_adr = 4'd0;
      #2;
      // reset values
      chk("rst_state", state, 0);
      chk("rst_rst_n", cpu_rst_n, 0);
      chk("rst_tick", cpu_tick, 0);
      chk("rst_cnt", instr_cnt, 0);
      chk("rst_bp_hit", bp_hit, 0);
      chk("rst_ready", hif.host_wr_ready, 1);
      step_clk();
      rst = 1'b0;

      // 1: load program in IDLE
      host_write(4'd0, 8'hB3);
      host_write(4'd1, 8'hB5);
      host_write(4'd2, 8'hF0);
      chk("idle_ready", hif.host_wr_ready, 1);
      cpu_adr = 4'd0; #1 chk("fetch0", cpu_dat, 8'hB3);
      cpu_adr = 4'd1; #1 chk("fetch1", cpu_dat, 8'hB5);
      cpu_adr = 4'd2; #1 chk("fetch2", cpu_dat, 8'hF0);
      chk("idle_rst_n", cpu_rst_n, 0);
      chk("idle_tick", cpu_tick, 0);

      // 2: run from IDLE, ticks every 4th cycle
      cmd_run = 1'b1;
      step_clk();
      cmd_run = 1'b0;
      chk("run_state", state, 1);
      chk("run_rst_n", cpu_rst_n, 1);
      for (int k = 0; k < 12; k++) begin
         chk("run_tick", cpu_tick, (k % 4) == 3);
         step_clk();
      end
      chk("run_cnt3", instr_cnt, 3);
      step_clk(); step_clk(); step_clk();

      // 3: halt on a tick-due cycle, then two single steps
      cmd_halt = 1'b1;
      #1 chk("halt_no_tick", cpu_tick, 0);
      step_clk();
      cmd_halt = 1'b0;
      chk("halt_state", state, 2);
      chk("halt_cnt", instr_cnt, 3);
      chk("halt_rst_n", cpu_rst_n, 1);
      for (int s = 0; s < 2; s++) begin
         cmd_step = 1'b1;
         #1 chk("step_cmd_no_tick", cpu_tick, 0);
         step_clk();
         cmd_step = 1'b0;
         chk("step_state", state, 3);
         chk("step_tick", cpu_tick, 1);
         step_clk();
         chk("step_back_halt", state, 2);
         chk("step_after_tick", cpu_tick, 0);
         chk("step_cnt", instr_cnt, 4 + s);
      end

      // 4: host write dropped during RUN, accepted in HALT
      cmd_run = 1'b1;
      step_clk();
      cmd_run = 1'b0;
      chk("resume_state", state, 1);
      hif.host_wr_valid = 1'b1; hif.host_wr_addr = 4'd1; hif.host_wr_data = 8'h00;
      #1 chk("run_not_ready", hif.host_wr_ready, 0);
      step_clk();
      hif.host_wr_valid = 1'b0;
      cpu_adr = 4'd1;
      #1 chk("run_wr_dropped", cpu_dat, 8'hB5);
      cmd_halt = 1'b1;
      step_clk();
      cmd_halt = 1'b0;
      chk("halt2_state", state, 2);
      chk("halt2_cnt", instr_cnt, 5);
      hif.host_wr_valid = 1'b1; hif.host_wr_addr = 4'd1; hif.host_wr_data = 8'h00;
      #1 chk("halt_ready", hif.host_wr_ready, 1);
      chk("pre_edge_old", cpu_dat, 8'hB5);
      step_clk();
      hif.host_wr_valid = 1'b0;
      #1 chk("post_edge_new", cpu_dat, 8'h00);
      cpu_adr = 4'd0;
      #1 chk("other_addr_kept", cpu_dat, 8'hB3);

      // 5: halt beats run; reset mid-run
      cmd_run = 1'b1;
      step_clk();
      chk("run3_state", state, 1);
      cmd_halt = 1'b1;
      step_clk();
      cmd_halt = 1'b0; cmd_run = 1'b0;
      chk("halt_over_run", state, 2);
      cmd_run = 1'b1;
      step_clk();
      cmd_run = 1'b0;
      step_clk(); step_clk();
      cmd_reset = 1'b1;
      step_clk();
      cmd_reset = 1'b0;
      chk("reset_state", state, 0);
      chk("reset_rst_n", cpu_rst_n, 0);
      chk("reset_cnt", instr_cnt, 0);
      chk("reset_ready", hif.host_wr_ready, 1);
      cmd_reset = 1'b1; cmd_run = 1'b1;
      step_clk();
      cmd_reset = 1'b0; cmd_run = 1'b0;
      chk("reset_over_run", state, 0);

      // 6: breakpoint at PC 2, bench plays the core's PC
      cpu_adr = 4'd0; bp_en = 1'b1; bp_addr = 4'd2;
      cmd_run = 1'b1;
      step_clk();
      cmd_run = 1'b0;
      for (int k = 0; k < 11; k++) begin
         cpu_adr = (k < 4) ? 4'd0 : ((k < 8) ? 4'd1 : 4'd2);
         #1 chk("bp_run_tick", cpu_tick, (k % 4) == 3);
         step_clk();
      end
      cpu_adr = 4'd2;
`ifdef TD4_BREAKPOINT_EN
      #1 chk("bp_tick_withheld", cpu_tick, 0);
      chk("bp_hit_pulse", bp_hit, 1);
      step_clk();
      chk("bp_halt_state", state, 2);
      chk("bp_hit_low", bp_hit, 0);
      chk("bp_cnt", instr_cnt, 2);
      cmd_run = 1'b1;
      step_clk();
      cmd_run = 1'b0;
      step_clk(); step_clk(); step_clk();
      chk("bp_resume_tick", cpu_tick, 1);
      chk("bp_resume_no_hit", bp_hit, 0);
      step_clk();
      cpu_adr = 4'd3;
      chk("bp_past_state", state, 1);
      chk("bp_past_cnt", instr_cnt, 3);
      step_clk(); step_clk(); step_clk();
      cpu_adr = 4'd2;
      #1 chk("bp_rearmed_tick", cpu_tick, 0);
      chk("bp_rearmed_hit", bp_hit, 1);
      step_clk();
      chk("bp_rearmed_state", state, 2);
`else
      #1 chk("nobp_tick", cpu_tick, 1);
      chk("nobp_hit", bp_hit, 0);
      step_clk();
      chk("nobp_state", state, 1);
      chk("nobp_cnt", instr_cnt, 3);
`endif

      // DIV=1 ticks every cycle; 3-bit counter stops at 7
      s_run = 1'b1;
      step_clk();
      s_run = 1'b0;
      chk("sat_state", s_state, 1);
      for (int k = 0; k < 10; k++) begin
         chk("sat_tick", s_tick, 1);
         step_clk();
      end
      chk("sat_cnt", s_cnt, 7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
